// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings, parity modes and sizing helper
package uart_pkg;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [5:0] {
        ST_IDLE      = 6'b000001,
        ST_START     = 6'b000010,
        ST_DATA      = 6'b000100,
        ST_PARITY    = 6'b001000,
        ST_STOP      = 6'b010000,
        ST_WAIT_IDLE = 6'b100000
    } rx_state_e;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int v = value; v > 0; v = v >> 1) r++;
        return r;
    endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: multi-flop synchroniser for the serial line, resets to idle-high
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_rx,
    output logic o_rxs
);
    logic [SYNC_STAGES-1:0] q;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) q <= '1;
        else          q <= {q[SYNC_STAGES-2:0], i_rx};
    end

    assign o_rxs = q[SYNC_STAGES-1];
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable oversampling UART receiver with parity, framing and break detection
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int NB_DATA     = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int NB_STOP     = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rxdone,
    output logic               o_parity_err,
    output logic               o_frame_err,
    output logic               o_break
);
    localparam int CW = clogb2(OVERSAMPLE - 1);
    localparam int IW = clogb2(NB_DATA);
    localparam logic [CW-1:0] HALF     = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST     = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(NB_DATA - 1);

    rx_state_e state, next_state;
    logic [CW-1:0] cnt, next_cnt;
    logic [IW-1:0] idx, next_idx;
    logic [NB_DATA-1:0] sr, next_sr, next_data;
    logic stop_n, next_stop_n, stop0, next_stop0, psamp, next_psamp;
    logic perr, next_perr, ferr, next_ferr;
    logic next_rxdone, next_parity_err, next_frame_err, next_break;
    logic rxs, samp, s0, fe_now, brk_now;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_rx    (i_rx),
        .o_rxs   (rxs)
    );

    assign samp    = i_tick && cnt == LAST;
    assign s0      = stop_n ? stop0 : rxs;
    assign fe_now  = ferr | ~rxs;
    assign brk_now = ~|sr & ~psamp & ~s0;

    always_comb begin
        next_state      = state;
        next_cnt        = i_tick ? cnt + 1'b1 : cnt;
        next_idx        = idx;
        next_sr         = sr;
        next_stop_n     = stop_n;
        next_stop0      = stop0;
        next_psamp      = psamp;
        next_perr       = perr;
        next_ferr       = ferr;
        next_data       = o_data;
        next_rxdone     = 1'b0;
        next_parity_err = o_parity_err;
        next_frame_err  = o_frame_err;
        next_break      = o_break;
        case (state)
            ST_IDLE: begin
                next_cnt = '0;
                if (!rxs) next_state = ST_START;
            end
            ST_START: if (i_tick && cnt == HALF) begin
                next_cnt    = '0;
                next_idx    = '0;
                next_stop_n = 1'b0;
                next_psamp  = 1'b0;
                next_perr   = 1'b0;
                next_ferr   = 1'b0;
                next_state  = rxs ? ST_IDLE : ST_DATA;
            end
            ST_DATA: if (samp) begin
                next_cnt = '0;
                next_sr  = {rxs, sr[NB_DATA-1:1]};
                next_idx = idx + 1'b1;
                if (idx == LAST_BIT) next_state = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (samp) begin
                next_cnt   = '0;
                next_psamp = rxs;
                next_perr  = rxs != ((PARITY_MODE == PARITY_ODD) ? ~^sr : ^sr);
                next_state = ST_STOP;
            end
            ST_STOP: if (samp) begin
                next_cnt    = '0;
                next_stop_n = 1'b1;
                next_stop0  = s0;
                next_ferr   = fe_now;
                // final stop sample completes the frame and publishes everything at once
                if (NB_STOP == 1 || stop_n) begin
                    next_data       = sr;
                    next_rxdone     = 1'b1;
                    next_parity_err = perr;
                    next_frame_err  = fe_now;
                    next_break      = brk_now;
                    next_state      = fe_now ? ST_WAIT_IDLE : ST_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                next_cnt = '0;
                if (rxs) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            idx          <= '0;
            sr           <= '0;
            stop_n       <= 1'b0;
            stop0        <= 1'b0;
            psamp        <= 1'b0;
            perr         <= 1'b0;
            ferr         <= 1'b0;
            o_data       <= '0;
            o_rxdone     <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
        end else begin
            state        <= next_state;
            cnt          <= next_cnt;
            idx          <= next_idx;
            sr           <= next_sr;
            stop_n       <= next_stop_n;
            stop0        <= next_stop0;
            psamp        <= next_psamp;
            perr         <= next_perr;
            ferr         <= next_ferr;
            o_data       <= next_data;
            o_rxdone     <= next_rxdone;
            o_parity_err <= next_parity_err;
            o_frame_err  <= next_frame_err;
            o_break      <= next_break;
        end
    end
endmodule
